// File: rtl/video_vga_scanout_pkg.sv
// Shared video definitions: line-buffer address layout, pixel width default and
// scan FSM encoding.
package video_vga_scanout_pkg;

    localparam int unsigned LB_ADDR_W     = 10;
    // Read address is {bank, pixel_index}
    localparam int unsigned LB_RD_ADDR_W  = LB_ADDR_W + 1;
    localparam int unsigned PIX_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        ScanIdle   = 2'd0,
        ScanFetch  = 2'd1,
        ScanActive = 2'd2
    } scan_state_e;

    function automatic logic [LB_RD_ADDR_W-1:0] lb_addr(input logic                 bank,
                                                         input logic [LB_ADDR_W-1:0] idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/video_vga_scanout_if.sv
// Line-buffer read port: the scanout block is the master, the RAM is the slave.
interface video_vga_scanout_if
    import video_vga_scanout_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEFAULT
) ();

    logic [LB_RD_ADDR_W-1:0] rd_addr;
    logic                    rd_en;
    logic [PIX_W-1:0]        rd_data;

    modport master (
        output rd_addr,
        output rd_en,
        input  rd_data
    );

    modport slave (
        input  rd_addr,
        input  rd_en,
        output rd_data
    );

endinterface

// File: rtl/video_pix_dim.sv
// Registered VGA output stage: optional per-channel halving for the scanline
// effect, forced to zero while blanked.
module video_pix_dim #(
    parameter int unsigned PIX_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix,
    input  logic             dim,
    input  logic             blank,
    output logic [PIX_W-1:0] vga_pixel,
    output logic             vga_blank
);

    logic [PIX_W-1:0] pix_dim;

    // Each 2-bit channel c becomes {0, c[1]}
    always_comb begin
        pix_dim = pix;
        if (dim) begin
            for (int i = 0; i < int'(PIX_W / 2); i++) begin
                pix_dim[2*i +: 2] = {1'b0, pix[2*i+1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_pixel <= '0;
            vga_blank <= 1'b1;
        end else begin
            vga_blank <= blank;
            vga_pixel <= blank ? '0 : pix_dim;
        end
    end

endmodule

// File: rtl/video_vga_scanout.sv
// Scan-doubler reader: replays the completed line-buffer bank once per VGA scanout
// start and drives the blanked pixel stream, dimming later passes on request.
module video_vga_scanout
    import video_vga_scanout_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = 720,
    parameter int unsigned PIX_W      = PIX_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hsync_start,
    input  logic                      scanout_start,
    input  logic                      scanlines_en,
    video_vga_scanout_if.master       lb,
    output logic [PIX_W-1:0]          vga_pixel,
    output logic                      vga_blank,
    output logic                      scan_second
);

    localparam logic [LB_ADDR_W-1:0] LastIdx = LB_ADDR_W'(ACTIVE_LEN - 1);

    scan_state_e          state_q, state_d;
    logic [LB_ADDR_W-1:0] addr_q, addr_d;
    logic                 rd_en_q, rd_en_d;
    logic                 valid_q;
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 started_q, started_d;
    logic                 scan_second_q, scan_second_d;
    logic                 started_clr;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_en_d       = 1'b0;
        wr_bank_d     = wr_bank_q ^ hsync_start;
        // hsync_start takes effect before a coincident scanout_start
        started_clr   = started_q & ~hsync_start;
        started_d     = started_clr;
        rd_bank_d     = rd_bank_q;
        scan_second_d = scan_second_q;

        if (scanout_start) begin
            state_d       = ScanFetch;
            addr_d        = '0;
            rd_en_d       = 1'b1;
            rd_bank_d     = ~wr_bank_d;
            scan_second_d = started_clr;
            started_d     = 1'b1;
        end else begin
            unique case (state_q)
                ScanIdle: ;
                ScanFetch, ScanActive: begin
                    if (state_q == ScanFetch) begin
                        state_d = ScanActive;
                    end
                    if (rd_en_q && (addr_q != LastIdx)) begin
                        addr_d  = addr_q + 1'b1;
                        rd_en_d = 1'b1;
                    end
                    // Last pixel is entering the output register on this edge
                    if (state_q == ScanActive && !rd_en_q && valid_q) begin
                        state_d = ScanIdle;
                    end
                end
                default: state_d = ScanIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ScanIdle;
            addr_q        <= '0;
            rd_en_q       <= 1'b0;
            valid_q       <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            started_q     <= 1'b0;
            scan_second_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rd_en_q       <= rd_en_d;
            valid_q       <= rd_en_q;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            started_q     <= started_d;
            scan_second_q <= scan_second_d;
        end
    end

    assign lb.rd_addr  = lb_addr(rd_bank_q, addr_q);
    assign lb.rd_en    = rd_en_q;
    assign scan_second = scan_second_q;

    video_pix_dim #(
        .PIX_W (PIX_W)
    ) u_pix_dim (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix       (lb.rd_data),
        .dim       (scanlines_en & scan_second_q),
        .blank     (~valid_q),
        .vga_pixel (vga_pixel),
        .vga_blank (vga_blank)
    );

endmodule
